// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-master data-memory arbiter: both master ports and the slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  localparam int unsigned SW = DW / 8;

  logic          m0_req;
  logic          m0_lock;
  logic [SW-1:0] m0_Write;
  logic [AW-1:0] m0_Addr;
  logic [DW-1:0] m0_WData;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_RData;

  logic          m1_req;
  logic          m1_lock;
  logic [SW-1:0] m1_Write;
  logic [AW-1:0] m1_Addr;
  logic [DW-1:0] m1_WData;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_RData;

  logic          s_re;
  logic [SW-1:0] s_Write;
  logic [AW-1:0] s_Addr;
  logic [DW-1:0] s_WData;
  logic [DW-1:0] s_RData;

  modport slave (
    input  m0_req, m0_lock, m0_Write, m0_Addr, m0_WData,
    output m0_gnt, m0_rvalid, m0_RData,
    input  m1_req, m1_lock, m1_Write, m1_Addr, m1_WData,
    output m1_gnt, m1_rvalid, m1_RData,
    output s_re, s_Write, s_Addr, s_WData,
    input  s_RData
  );

  modport master (
    output m0_req, m0_lock, m0_Write, m0_Addr, m0_WData,
    input  m0_gnt, m0_rvalid, m0_RData,
    output m1_req, m1_lock, m1_Write, m1_Addr, m1_WData,
    input  m1_gnt, m1_rvalid, m1_RData,
    input  s_re, s_Write, s_Addr, s_WData,
    output s_RData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: round-robin with bounded lock ownership, and in-order
// routing of read data back to the issuing master through a latency-matched tag pipeline.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned SW      = DW / 8;
  localparam logic [7:0]  HoldMax = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            r_state;
  logic              r_last;
  logic [7:0]        r_hold_cnt;
  logic [RD_LAT-1:0] r_rd_vld;
  logic [RD_LAT-1:0] r_rd_idx;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_arb;
  logic          w_any;
  logic          w_sel;
  logic          w_sel_lock;
  logic          w_other_req;
  logic          w_rd;
  logic          w_release;
  logic          w_rv0;
  logic          w_rv1;
  logic [SW-1:0] w_sel_write;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic [7:0]    w_hold_inc;

  // w_arb marks a cycle decided by round-robin rather than by an owner continuing its lock.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    w_arb  = 1'b1;
    if (r_state == StOwn0 && bus.m0_req) begin
      w_gnt0 = 1'b1;
      w_arb  = 1'b0;
    end else if (r_state == StOwn1 && bus.m1_req) begin
      w_gnt1 = 1'b1;
      w_arb  = 1'b0;
    end else if (bus.m0_req && bus.m1_req) begin
      w_gnt0 = r_last;
      w_gnt1 = ~r_last;
    end else begin
      w_gnt0 = bus.m0_req;
      w_gnt1 = bus.m1_req;
    end
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any       = w_gnt0 | w_gnt1;
  assign w_sel       = w_gnt1;
  assign w_sel_lock  = w_sel ? bus.m1_lock  : bus.m0_lock;
  assign w_other_req = w_sel ? bus.m0_req   : bus.m1_req;
  assign w_sel_write = w_sel ? bus.m1_Write : bus.m0_Write;
  assign w_sel_addr  = w_sel ? bus.m1_Addr  : bus.m0_Addr;
  assign w_sel_wdata = w_sel ? bus.m1_WData : bus.m0_WData;
  assign w_rd        = w_any & ~(|w_sel_write);

  // Counter saturates so an uncontended owner can keep the bus indefinitely.
  assign w_hold_inc = (r_hold_cnt >= HoldMax) ? r_hold_cnt : r_hold_cnt + 8'd1;
  assign w_release  = ~w_sel_lock | ((w_hold_inc == HoldMax) & w_other_req);

  assign bus.m0_gnt  = w_gnt0;
  assign bus.m1_gnt  = w_gnt1;
  assign bus.s_re    = w_rd;
  assign bus.s_Write = w_any ? w_sel_write : '0;
  assign bus.s_Addr  = w_any ? w_sel_addr  : '0;
  assign bus.s_WData = w_any ? w_sel_wdata : '0;

  assign w_rv0         = r_rd_vld[RD_LAT-1] & ~r_rd_idx[RD_LAT-1];
  assign w_rv1         = r_rd_vld[RD_LAT-1] & r_rd_idx[RD_LAT-1];
  assign bus.m0_rvalid = w_rv0;
  assign bus.m1_rvalid = w_rv1;
  assign bus.m0_RData  = w_rv0 ? bus.s_RData : '0;
  assign bus.m1_RData  = w_rv1 ? bus.s_RData : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_last     <= 1'b1;
      r_hold_cnt <= '0;
      r_rd_vld   <= '0;
      r_rd_idx   <= '0;
    end else begin
      r_rd_vld[0] <= w_rd;
      r_rd_idx[0] <= w_sel;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_idx[i] <= r_rd_idx[i-1];
      end

      if (w_any) begin
        r_last <= w_sel;
      end

      if (w_any && w_arb) begin
        r_hold_cnt <= '0;
        if (w_sel_lock) begin
          r_state <= w_sel ? StOwn1 : StOwn0;
        end else begin
          r_state <= StIdle;
        end
      end else if (w_any) begin
        if (w_release) begin
          r_state    <= StIdle;
          r_hold_cnt <= '0;
        end else begin
          r_hold_cnt <= w_hold_inc;
        end
      end else begin
        r_state    <= StIdle;
        r_hold_cnt <= '0;
      end
    end
  end

  a_one_grant : assert property (@(posedge clk) disable iff (rst) !(w_gnt0 && w_gnt1));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (read latency 1, 2, 3) share one stimulus stream and
// are compared every cycle against a transaction-level reference model.
module tb_dmem_arbiter;
  localparam int NInst   = 3;
  localparam int MaxHold = 4;
  localparam int HistLen = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        lock  [2];
  logic [3:0]  wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];

  logic [NInst-1:0] o_g0, o_g1, o_re, o_rv0, o_rv1;
  logic [3:0]       o_wr   [NInst];
  logic [31:0]      o_addr [NInst];
  logic [31:0]      o_wd   [NInst];
  logic [31:0]      o_rd0  [NInst];
  logic [31:0]      o_rd1  [NInst];

  // Slave memory contents: a fixed function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  for (genvar k = 0; k < NInst; k++) begin : g_lat
    localparam int unsigned Lat = k + 1;
    logic [31:0] r_pipe [Lat];

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(
      .AW(32), .DW(32), .RD_LAT(Lat), .MAX_HOLD(MaxHold)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.m0_req   = req[0];
    assign bus.m0_lock  = lock[0];
    assign bus.m0_Write = wr[0];
    assign bus.m0_Addr  = addr[0];
    assign bus.m0_WData = wdata[0];
    assign bus.m1_req   = req[1];
    assign bus.m1_lock  = lock[1];
    assign bus.m1_Write = wr[1];
    assign bus.m1_Addr  = addr[1];
    assign bus.m1_WData = wdata[1];

    always @(posedge clk) begin
      r_pipe[0] <= bus.s_re ? memf(bus.s_Addr) : 32'hDEAD_BEEF;
      for (int i = 1; i < int'(Lat); i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign bus.s_RData = r_pipe[Lat-1];

    assign o_g0[k]   = bus.m0_gnt;
    assign o_g1[k]   = bus.m1_gnt;
    assign o_re[k]   = bus.s_re;
    assign o_rv0[k]  = bus.m0_rvalid;
    assign o_rv1[k]  = bus.m1_rvalid;
    assign o_wr[k]   = bus.s_Write;
    assign o_addr[k] = bus.s_Addr;
    assign o_wd[k]   = bus.s_WData;
    assign o_rd0[k]  = bus.m0_RData;
    assign o_rd1[k]  = bus.m1_RData;
  end

  int n_checks, n_fail, cyc;
  int m_owner, m_run;
  logic m_last;
  logic        h_rd   [HistLen];
  logic        h_m    [HistLen];
  logic [31:0] h_addr [HistLen];
  int cnt_g0, cnt_g1, cnt_rv0_any, cnt_rv1_l1, cnt_rv1_l2, cnt_rv_l3;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
    end
  endtask

  task automatic set_m(input int n, input logic r, input logic l, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d);
    req[n] = r;  lock[n] = l;  wr[n] = w;  addr[n] = a;  wdata[n] = d;
  endtask

  task automatic idle();
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Called just after a falling edge with inputs applied; checks, advances model, waits an edge.
  task automatic step();
    int g, lat, src;
    logic owned;
    logic [3:0] e_wr;
    logic [31:0] e_addr, e_wd;
    logic e_re;
    logic e_rv [2];
    logic [31:0] e_rd [2];
    #1;
    g = -1;
    owned = 1'b0;
    if (!rst) begin
      if (m_owner >= 0 && req[m_owner]) begin
        g = m_owner;
        owned = 1'b1;
      end else if (req[0] && req[1]) g = m_last ? 0 : 1;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
    end
    e_wr = 4'h0;  e_addr = 32'h0;  e_wd = 32'h0;
    if (g >= 0) begin
      e_wr = wr[g];  e_addr = addr[g];  e_wd = wdata[g];
    end
    e_re = (g >= 0) && (e_wr == 4'h0);

    for (int k = 0; k < NInst; k++) begin
      lat = k + 1;
      e_rv[0] = 1'b0;  e_rv[1] = 1'b0;  e_rd[0] = 32'h0;  e_rd[1] = 32'h0;
      if (!rst && cyc >= lat && h_rd[cyc-lat]) begin
        src = h_m[cyc-lat] ? 1 : 0;
        e_rv[src] = 1'b1;
        e_rd[src] = memf(h_addr[cyc-lat]);
      end
      check($sformatf("gnt0_L%0d", lat), 32'(o_g0[k]), 32'(g == 0));
      check($sformatf("gnt1_L%0d", lat), 32'(o_g1[k]), 32'(g == 1));
      check($sformatf("s_re_L%0d", lat), 32'(o_re[k]), 32'(e_re));
      check($sformatf("s_Write_L%0d", lat), 32'(o_wr[k]), 32'(e_wr));
      check($sformatf("s_Addr_L%0d", lat), o_addr[k], e_addr);
      check($sformatf("s_WData_L%0d", lat), o_wd[k], e_wd);
      check($sformatf("rvalid0_L%0d", lat), 32'(o_rv0[k]), 32'(e_rv[0]));
      check($sformatf("rvalid1_L%0d", lat), 32'(o_rv1[k]), 32'(e_rv[1]));
      check($sformatf("rdata0_L%0d", lat), o_rd0[k], e_rd[0]);
      check($sformatf("rdata1_L%0d", lat), o_rd1[k], e_rd[1]);
    end

    cnt_g0      += int'(o_g0[0]);
    cnt_g1      += int'(o_g1[0]);
    cnt_rv0_any += int'(|o_rv0);
    cnt_rv1_l1  += int'(o_rv1[0]);
    cnt_rv1_l2  += int'(o_rv1[1]);
    cnt_rv_l3   += int'(o_rv0[2] | o_rv1[2]);

    h_rd[cyc]   = e_re;
    h_m[cyc]    = (g == 1);
    h_addr[cyc] = e_addr;

    if (rst) begin
      m_owner = -1;
      m_run   = 0;
      m_last  = 1'b1;
      for (int j = 0; j <= cyc; j++) h_rd[j] = 1'b0;
    end else if (g >= 0) begin
      m_last = (g == 1);
      m_run  = owned ? m_run + 1 : 1;
      if (lock[g] && !(owned && m_run >= MaxHold && req[1-g])) begin
        m_owner = g;
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end else begin
      m_owner = -1;
      m_run   = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_counts();
    cnt_g0 = 0;  cnt_g1 = 0;  cnt_rv0_any = 0;
    cnt_rv1_l1 = 0;  cnt_rv1_l2 = 0;  cnt_rv_l3 = 0;
  endtask

  initial begin
    n_checks = 0;  n_fail = 0;  cyc = 0;
    m_owner = -1;  m_run = 0;  m_last = 1'b1;
    for (int j = 0; j < HistLen; j++) h_rd[j] = 1'b0;
    clear_counts();
    rst = 1'b1;
    idle();
    @(negedge clk);

    // Reset held with requests pending: everything must stay quiet.
    set_m(0, 1'b1, 1'b1, 4'h0, 32'h40, 32'h0);
    set_m(1, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    step();
    step();
    rst = 1'b0;
    idle();
    step();

    // Simultaneous first reads: m0 wins, m1 follows.
    clear_counts();
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    set_m(1, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    step();
    check("req025_first_m0", 32'(cnt_g0), 32'd1);
    set_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    check("req025_then_m1", 32'(cnt_g1), 32'd1);
    idle();
    repeat (3) step();

    // Lock contention: m1 keeps 4 beats, then m0.
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
    step();
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
    set_m(1, 1'b1, 1'b1, 4'h0, 32'h38, 32'h0);
    clear_counts();
    repeat (4) step();
    check("req026_m1_beats", 32'(cnt_g1), 32'd4);
    check("req026_m0_none", 32'(cnt_g0), 32'd0);
    step();
    check("req026_m0_5th", 32'(cnt_g0), 32'd1);
    idle();
    repeat (3) step();

    // Uncontended lock: no forced release, then release once m1 asks.
    set_m(0, 1'b1, 1'b1, 4'h0, 32'h70, 32'h0);
    clear_counts();
    repeat (20) step();
    check("req027_m0_beats", 32'(cnt_g0), 32'd20);
    check("req027_m1_none", 32'(cnt_g1), 32'd0);
    set_m(1, 1'b1, 1'b0, 4'h0, 32'h74, 32'h0);
    clear_counts();
    step();
    check("req027_release_beat", 32'(cnt_g0), 32'd1);
    step();
    check("req027_m1_after", 32'(cnt_g1), 32'd1);
    idle();
    repeat (3) step();

    // Write then read.
    clear_counts();
    set_m(0, 1'b1, 1'b0, 4'b0011, 32'h50, 32'hAABB_CCDD);
    step();
    idle();
    set_m(1, 1'b1, 1'b0, 4'h0, 32'h54, 32'h0);
    step();
    idle();
    repeat (4) step();
    check("req028_m0_rvalid", 32'(cnt_rv0_any), 32'd0);
    check("req028_m1_rvalid", 32'(cnt_rv1_l1), 32'd1);

    // Reset with a read in flight.
    set_m(1, 1'b1, 1'b0, 4'h0, 32'h60, 32'h0);
    step();
    rst = 1'b1;
    set_m(0, 1'b1, 1'b0, 4'h0, 32'h64, 32'h0);
    set_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step();
    rst = 1'b0;
    idle();
    clear_counts();
    repeat (5) step();
    check("req029_no_m1_rvalid", 32'(cnt_rv1_l2), 32'd0);

    // Alternating reads, back to back.
    clear_counts();
    for (int i = 0; i < 8; i++) begin
      idle();
      set_m(i % 2, 1'b1, 1'b0, 4'h0, 32'h100 + 32'(4 * i), 32'h0);
      step();
    end
    idle();
    repeat (4) step();
    check("req030_pulses", 32'(cnt_rv_l3), 32'd8);

    // Random traffic with occasional resets.
    repeat (1500) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int n = 0; n < 2; n++) begin
        set_m(n, ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0,
              $urandom() & 32'hFFFF_FFFC, $urandom());
      end
      step();
    end
    rst = 1'b0;
    idle();
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
